// File: rtl/rx_vote_scheduler_if.sv
// rtl/rx_vote_scheduler_if.sv - vote command handshake between rx scheduler and majority voter
interface rx_vote_scheduler_if #(
   parameter int MAX_REDUNDANCY = 3
);
   logic                      vote_valid;
   logic                      vote_ready;
   logic [15:0]               vote_seg;
   logic [7:0]                vote_aux;
   logic [MAX_REDUNDANCY-1:0] vote_mask;
   logic                      loss_detected;

   modport master (
      output vote_valid, vote_seg, vote_aux, vote_mask, loss_detected,
      input  vote_ready
   );

   modport slave (
      input  vote_valid, vote_seg, vote_aux, vote_mask, loss_detected,
      output vote_ready
   );
endinterface

// File: rtl/rx_vote_scheduler.sv
// rtl/rx_vote_scheduler.sv - redundancy header parser, ping-pong copy bitmaps and vote dispatcher
module rx_vote_scheduler #(
   parameter int WHEREIS_SEGMENT_NUM = 34,
   parameter int SEGMENT_NUM_MAX     = 5,
   parameter int MAX_REDUNDANCY      = 3,
   parameter int TIMEOUT_CYCLES      = 4096
) (
   input  logic        clk125MHz,
   input  logic        reset,
   input  logic        rx_enable,
   input  logic [7:0]  rx_data,
   input  logic [7:0]  redundancy,
   output logic        hdr_valid,
   output logic [1:0]  wr_slot,
   output logic [15:0] wr_seg,
   output logic        overrun,
   output logic        busy,
   rx_vote_scheduler_if.master vote
);
   localparam int SEG_W = (SEGMENT_NUM_MAX > 1) ? $clog2(SEGMENT_NUM_MAX) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   logic [15:0]               byte_cnt;
   logic [7:0]                seg_hi, seg_lo, id_r, pkt_aux;
   logic [7:0]                cur_aux, disp_aux;
   logic                      pkt_ok, group_open, fill;
   logic [TMO_W-1:0]          tmo_cnt;
   logic [1:0]                state;
   logic [SEG_W-1:0]          seg_idx;
   logic [MAX_REDUNDANCY-1:0] bank [2][SEGMENT_NUM_MAX];

   logic [7:0]                eff_red, majority, pop;
   logic [MAX_REDUNDANCY-1:0] red_mask, cur_mask;
   logic [SEG_W-1:0]          wr_idx;
   logic at_aux, hdr_ok, commit, aux_change, swap, drop, write_en, write_bank, disp_bank;
   logic all_full, tmo_hit, close_full, close_tmo, close, handshake;

   always_comb begin
      eff_red = redundancy;
      if (redundancy == 8'd0)
         eff_red = 8'd1;
      else if (redundancy > 8'(MAX_REDUNDANCY))
         eff_red = 8'(MAX_REDUNDANCY);
      majority = (eff_red >> 1) + 8'd1;
      red_mask = '0;
      for (int k = 0; k < MAX_REDUNDANCY; k++)
         red_mask[k] = (32'(k) < 32'(eff_red));
   end

   always_comb begin
      at_aux = rx_enable && (byte_cnt == 16'(WHEREIS_SEGMENT_NUM + 3));
      hdr_ok = at_aux && (id_r != 8'd0) && (id_r <= eff_red) &&
               ({seg_hi, seg_lo} < 16'(SEGMENT_NUM_MAX));
   end

   // Commit is the first idle cycle after a packet; pkt_ok is cleared by that same cycle.
   always_comb begin
      wr_idx     = wr_seg[SEG_W-1:0];
      disp_bank  = ~fill;
      commit     = !rx_enable && pkt_ok;
      aux_change = commit && group_open && (pkt_aux != cur_aux);
      swap       = aux_change && !busy;
      drop       = aux_change && busy;
      write_en   = commit && !drop;
      write_bank = swap ? ~fill : fill;
      all_full   = 1'b1;
      for (int s = 0; s < SEGMENT_NUM_MAX; s++)
         if (bank[fill][s] != red_mask)
            all_full = 1'b0;
      tmo_hit    = group_open && !rx_enable && (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
      close_full = group_open && all_full && !busy && !commit;
      close_tmo  = tmo_hit && !busy && !commit;
      close      = swap || close_full || close_tmo;
   end

   always_ff @(posedge clk125MHz or negedge reset) begin
      if (!reset) begin
         byte_cnt  <= '0;
         seg_hi    <= '0;
         seg_lo    <= '0;
         id_r      <= '0;
         pkt_aux   <= '0;
         pkt_ok    <= 1'b0;
         hdr_valid <= 1'b0;
         wr_slot   <= '0;
         wr_seg    <= '0;
      end else begin
         hdr_valid <= hdr_ok;
         if (rx_enable) begin
            if (byte_cnt != 16'hFFFF)
               byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == 16'(WHEREIS_SEGMENT_NUM))
               seg_hi <= rx_data;
            if (byte_cnt == 16'(WHEREIS_SEGMENT_NUM + 1))
               seg_lo <= rx_data;
            if (byte_cnt == 16'(WHEREIS_SEGMENT_NUM + 2))
               id_r <= rx_data;
            if (at_aux) begin
               pkt_aux <= rx_data;
               pkt_ok  <= hdr_ok;
            end
         end else begin
            byte_cnt <= '0;
            pkt_ok   <= 1'b0;
         end
         if (hdr_ok) begin
            wr_slot <= 2'(id_r - 8'd1);
            wr_seg  <= {seg_hi, seg_lo};
         end
      end
   end

   always_ff @(posedge clk125MHz or negedge reset) begin
      if (!reset) begin
         group_open <= 1'b0;
         cur_aux    <= '0;
         disp_aux   <= '0;
         fill       <= 1'b0;
         tmo_cnt    <= '0;
         overrun    <= 1'b0;
      end else begin
         overrun <= drop;
         if (close) begin
            fill     <= ~fill;
            disp_aux <= cur_aux;
         end
         if (write_en && (!group_open || swap)) begin
            group_open <= 1'b1;
            cur_aux    <= pkt_aux;
         end else if (close_full || close_tmo) begin
            group_open <= 1'b0;
         end
         if (rx_enable || commit || close)
            tmo_cnt <= '0;
         else if (group_open && (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)))
            tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // The fill bank and the dispatch bank are always opposite, so writes never collide.
   always_ff @(posedge clk125MHz or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++)
            for (int s = 0; s < SEGMENT_NUM_MAX; s++)
               bank[b][s] <= '0;
      end else begin
         if (write_en)
            bank[write_bank][wr_idx] <= bank[write_bank][wr_idx] |
                                        (MAX_REDUNDANCY'(1) << wr_slot);
         if (state == ST_CLEAR)
            for (int s = 0; s < SEGMENT_NUM_MAX; s++)
               bank[disp_bank][s] <= '0;
      end
   end

   always_ff @(posedge clk125MHz or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         seg_idx <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (close) begin
                  state   <= ST_ISSUE;
                  seg_idx <= '0;
               end
            ST_ISSUE:
               if (handshake) begin
                  if (seg_idx == SEG_W'(SEGMENT_NUM_MAX - 1))
                     state <= ST_CLEAR;
                  else
                     seg_idx <= seg_idx + SEG_W'(1);
               end
            ST_CLEAR: begin
               state   <= ST_IDLE;
               seg_idx <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy             = (state != ST_IDLE);
      cur_mask         = bank[disp_bank][seg_idx];
      vote.vote_valid  = (state == ST_ISSUE);
      vote.vote_seg    = vote.vote_valid ? 16'(seg_idx) : 16'd0;
      vote.vote_aux    = vote.vote_valid ? disp_aux : 8'd0;
      vote.vote_mask   = vote.vote_valid ? cur_mask : '0;
      handshake        = vote.vote_valid && vote.vote_ready;
      pop              = '0;
      for (int k = 0; k < MAX_REDUNDANCY; k++)
         pop = pop + 8'(cur_mask[k]);
      vote.loss_detected = handshake && (pop < majority);
   end
endmodule

// File: tb/tb_rx_vote_scheduler.sv
// tb/tb_rx_vote_scheduler.sv - directed scoreboard bench for rx_vote_scheduler
module tb_rx_vote_scheduler;
   localparam int W    = 34;
   localparam int NSEG = 5;
   localparam int MAXR = 3;
   localparam int TMO  = 4096;

   typedef struct packed {
      logic [15:0] seg;
      logic [7:0]  aux;
      logic [2:0]  mask;
      logic        loss;
   } vote_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_enable = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic [7:0]  redundancy = 8'd3;
   logic        hdr_valid, overrun, busy;
   logic [1:0]  wr_slot;
   logic [15:0] wr_seg;

   int tests = 0;
   int fails = 0;
   int hdr_cnt = 0;
   int ovr_cnt = 0;
   vote_t sb[$];

   rx_vote_scheduler_if #(.MAX_REDUNDANCY(MAXR)) vif ();

   rx_vote_scheduler #(
      .WHEREIS_SEGMENT_NUM(W),
      .SEGMENT_NUM_MAX(NSEG),
      .MAX_REDUNDANCY(MAXR),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk125MHz (clk),
      .reset     (rst_n),
      .rx_enable (rx_enable),
      .rx_data   (rx_data),
      .redundancy(redundancy),
      .hdr_valid (hdr_valid),
      .wr_slot   (wr_slot),
      .wr_seg    (wr_seg),
      .overrun   (overrun),
      .busy      (busy),
      .vote      (vif)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_vote(input int seg, input int aux, input int mask, input int loss);
      vote_t v;
      v.seg  = 16'(seg);
      v.aux  = 8'(aux);
      v.mask = 3'(mask);
      v.loss = 1'(loss);
      sb.push_back(v);
   endtask

   task automatic send(input int seg, input int id, input int aux, input int len);
      logic [15:0] s16;
      s16 = 16'(seg);
      for (int i = 0; i < len; i++) begin
         rx_enable = 1'b1;
         if (i == W)          rx_data = s16[15:8];
         else if (i == W + 1) rx_data = s16[7:0];
         else if (i == W + 2) rx_data = 8'(id);
         else if (i == W + 3) rx_data = 8'(aux);
         else                 rx_data = 8'(i) ^ 8'h5A;
         tick();
      end
      rx_enable = 1'b0;
      rx_data   = 8'd0;
      tick();
   endtask

   task automatic send_group(input int aux);
      for (int s = 0; s < NSEG; s++)
         for (int id = 1; id <= MAXR; id++)
            send(s, id, aux, 40);
   endtask

   task automatic wait_dispatch(input string tag);
      int k = 0;
      while (busy !== 1'b1 && k < 20) begin tick(); k++; end
      check({tag, "_started"}, 32'(busy), 32'd1);
      k = 0;
      while (busy !== 1'b0 && k < 400) begin tick(); k++; end
      check({tag, "_finished"}, 32'(busy), 32'd0);
      check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (vif.vote_valid !== 1'b1 && k < 20) begin tick(); k++; end
      check(tag, 32'(vif.vote_valid), 32'd1);
   endtask

   // Scoreboard consumer: every handshake must match the next expected command.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hdr_valid) hdr_cnt++;
         if (overrun) ovr_cnt++;
         if (vif.vote_valid && vif.vote_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_vote", 32'(vif.vote_seg), 32'hFFFF_FFFF);
            end else begin
               vote_t e;
               e = sb.pop_front();
               check("vote_seg",  32'(vif.vote_seg),      32'(e.seg));
               check("vote_aux",  32'(vif.vote_aux),      32'(e.aux));
               check("vote_mask", 32'(vif.vote_mask),     32'(e.mask));
               check("vote_loss", 32'(vif.loss_detected), 32'(e.loss));
            end
         end else if (vif.loss_detected) begin
            check("loss_without_handshake", 32'(vif.loss_detected), 32'd0);
         end
      end
   end

   initial begin
      int k;
      int h0;
      vif.vote_ready = 1'b0;
      tick();
      tick();
      check("rst_vote_valid", 32'(vif.vote_valid), 32'd0);
      check("rst_busy",       32'(busy),           32'd0);
      check("rst_hdr_valid",  32'(hdr_valid),      32'd0);
      check("rst_overrun",    32'(overrun),        32'd0);
      check("rst_vote_mask",  32'(vif.vote_mask),  32'd0);
      rst_n = 1'b1;
      tick();

      // Complete group closes on its own.
      vif.vote_ready = 1'b1;
      for (int s = 0; s < NSEG; s++) expect_vote(s, 0, 7, 0);
      send_group(0);
      wait_dispatch("full_group");
      check("hdr_valid_count", 32'(hdr_cnt), 32'd15);

      // Aux change closes a group missing one copy.
      for (int s = 0; s < NSEG; s++) expect_vote(s, 1, (s == 3) ? 5 : 7, 0);
      for (int s = 0; s < NSEG; s++)
         for (int id = 1; id <= MAXR; id++)
            if (!(s == 3 && id == 2)) send(s, id, 1, 40);
      send(0, 1, 2, 40);
      wait_dispatch("aux_change");

      // Group 2 with a single copy of seg 1, dispatched under backpressure.
      expect_vote(0, 2, 7, 0);
      expect_vote(1, 2, 1, 1);
      for (int s = 2; s < NSEG; s++) expect_vote(s, 2, 7, 0);
      send(0, 2, 2, 40);
      send(0, 3, 2, 40);
      send(1, 1, 2, 40);
      for (int s = 2; s < NSEG; s++)
         for (int id = 1; id <= MAXR; id++) send(s, id, 2, 40);
      vif.vote_ready = 1'b0;
      send(0, 1, 3, 40);
      wait_valid("bp_valid");
      check("bp_first_seg", 32'(vif.vote_seg), 32'd0);
      vif.vote_ready = 1'b1;
      tick();
      tick();
      vif.vote_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("bp_hold_valid", 32'(vif.vote_valid), 32'd1);
         check("bp_hold_seg",   32'(vif.vote_seg),   32'd2);
         check("bp_hold_mask",  32'(vif.vote_mask),  32'd7);
         tick();
      end
      vif.vote_ready = 1'b1;
      wait_dispatch("backpressure");

      // Group 3 closed by aux 5; group 5 then force-closed by timeout.
      expect_vote(0, 3, 1, 1);
      for (int s = 1; s < NSEG; s++) expect_vote(s, 3, 0, 1);
      send(0, 1, 5, 40);
      send(0, 2, 5, 40);
      send(0, 3, 5, 40);
      send(1, 1, 5, 40);
      check("g3_done_before_timeout", 32'(sb.size()), 32'd0);
      expect_vote(0, 5, 7, 0);
      expect_vote(1, 5, 1, 1);
      for (int s = 2; s < NSEG; s++) expect_vote(s, 5, 0, 1);
      k = 0;
      do begin tick(); k++; end while (busy !== 1'b1 && k < 5000);
      check("timeout_latency", 32'(k), 32'(TMO));
      wait_dispatch("timeout");

      // Runt, bad id and bad seg must not commit anything.
      h0 = hdr_cnt;
      send(0, 1, 6, 36);
      send(0, 4, 6, 40);
      send(5, 1, 6, 40);
      tick();
      check("filtered_no_hdr_valid", 32'(hdr_cnt), 32'(h0));

      // Third aux while the dispatcher is stalled is dropped.
      vif.vote_ready = 1'b0;
      expect_vote(0, 7, 1, 1);
      for (int s = 1; s < NSEG; s++) expect_vote(s, 7, 0, 1);
      send(0, 1, 7, 40);
      send(0, 2, 8, 40);
      send(0, 3, 9, 40);
      tick();
      check("overrun_pulses", 32'(ovr_cnt), 32'd1);
      vif.vote_ready = 1'b1;
      wait_dispatch("overrun_g7");
      expect_vote(0, 8, 2, 1);
      for (int s = 1; s < NSEG; s++) expect_vote(s, 8, 0, 1);
      send(1, 1, 10, 40);
      wait_dispatch("overrun_g8");

      // Reset while seg 2 of group 10 is pending.
      expect_vote(0, 10, 0, 1);
      expect_vote(1, 10, 1, 1);
      vif.vote_ready = 1'b0;
      send(0, 1, 11, 40);
      wait_valid("rstmid_valid");
      vif.vote_ready = 1'b1;
      tick();
      tick();
      vif.vote_ready = 1'b0;
      check("rstmid_seg_before", 32'(vif.vote_seg), 32'd2);
      rst_n = 1'b0;
      #1;
      check("rstmid_vote_valid", 32'(vif.vote_valid), 32'd0);
      check("rstmid_busy",       32'(busy),           32'd0);
      check("rstmid_vote_seg",   32'(vif.vote_seg),   32'd0);
      check("rstmid_vote_mask",  32'(vif.vote_mask),  32'd0);
      check("rstmid_vote_aux",   32'(vif.vote_aux),   32'd0);
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      vif.vote_ready = 1'b1;
      tick();
      for (int s = 0; s < NSEG; s++) expect_vote(s, 0, 7, 0);
      send_group(0);
      wait_dispatch("after_reset");
      check("overrun_total", 32'(ovr_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
